// File: rtl/ttt_pkg.sv
// ttt_pkg: definitions shared by the tic-tac-toe move-input block.
//   - Button index constants. Lower index means higher arbitration priority,
//     so the order place > up > down > left > right falls out of the numbering.
//   - One-hot encodings of the arbitration FSM states.
//   - Default debounce settings: 10 ms at 50 MHz.
//   - pick_priority(): isolates the highest-priority set bit of a level vector.
package ttt_pkg;

    localparam int NUM_BTNS = 5;

    localparam int BTN_C = 0;
    localparam int BTN_U = 1;
    localparam int BTN_D = 2;
    localparam int BTN_L = 3;
    localparam int BTN_R = 4;

    localparam int DEBOUNCE_CYCLES_DEF = 500000;
    localparam int CNT_W_DEF           = 20;

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_HELD = 3'b010,
        S_LOCK = 3'b100
    } state_t;

    // Returns a one-hot vector that keeps only the lowest-index set bit of
    // lvl. The lowest index is the highest-priority button. If no bit is set,
    // the result is all zeros.
    function automatic logic [NUM_BTNS-1:0] pick_priority(input logic [NUM_BTNS-1:0] lvl);
        logic [NUM_BTNS-1:0] result;
        result = '0;
        for (int i = NUM_BTNS - 1; i >= 0; i--) begin
            if (lvl[i]) begin
                result    = '0;
                result[i] = 1'b1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/ttt_debounce.sv
// ttt_debounce: conditions one raw push-button.
//   - A two-flop synchronizer is followed by a stability counter.
//   - The debounced level changes only after the synchronized input has
//     disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
//   - Any shorter excursion restarts the count.
// Ports:
//   Clk    in   system clock
//   Reset  in   synchronous active-low reset
//   btn    in   raw asynchronous button, 1 = pressed
//   stable out  debounced level
module ttt_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
)(
    input  logic Clk,
    input  logic Reset,
    input  logic btn,
    output logic stable
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync1_r;
    logic             sync2_r;
    logic             stable_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronizer chain plus debounce counter.
    // cnt_r counts consecutive cycles of disagreement and never exceeds CNT_MAX.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            sync1_r  <= 1'b0;
            sync2_r  <= 1'b0;
            stable_r <= 1'b0;
            cnt_r    <= '0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
            if (sync2_r == stable_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_MAX) begin
                stable_r <= sync2_r;
                cnt_r    <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    assign stable = stable_r;

endmodule

// File: rtl/ttt_move_input.sv
// ttt_move_input: debounces the five board buttons and turns each accepted
// press into a single-cycle move event for the game FSM.
//   - When a press is accepted while Enable is high, one pulse is issued for
//     the highest-priority button. The block then waits until every button
//     is released before it arbitrates again.
//   - A press seen while Enable is low locks the block until full release.
//     That press is therefore never delivered late.
// Ports:
//   Clk                          in   system clock
//   Reset                        in   synchronous active-low reset
//   BtnL/BtnR/BtnU/BtnD/BtnC     in   raw buttons, 1 = pressed
//   Enable                       in   game is waiting for a move
//   left/right/up/down/place     out  single-cycle move event pulses (registered)
//   held                         out  accepted press not yet fully released (registered)
//   any_stable                   out  OR of the debounced levels
module ttt_move_input
    import ttt_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
)(
    input  logic Clk,
    input  logic Reset,
    input  logic BtnL,
    input  logic BtnR,
    input  logic BtnU,
    input  logic BtnD,
    input  logic BtnC,
    input  logic Enable,
    output logic left,
    output logic right,
    output logic up,
    output logic down,
    output logic place,
    output logic held,
    output logic any_stable
);

    logic [NUM_BTNS-1:0] btn_raw_s;
    logic [NUM_BTNS-1:0] stable_s;
    logic [NUM_BTNS-1:0] pulse_next_s;
    logic [NUM_BTNS-1:0] pulse_r;
    state_t              state_r;
    state_t              state_next_s;
    logic                held_r;

    assign btn_raw_s[BTN_C] = BtnC;
    assign btn_raw_s[BTN_U] = BtnU;
    assign btn_raw_s[BTN_D] = BtnD;
    assign btn_raw_s[BTN_L] = BtnL;
    assign btn_raw_s[BTN_R] = BtnR;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_db
        ttt_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_db (
            .Clk    (Clk),
            .Reset  (Reset),
            .btn    (btn_raw_s[i]),
            .stable (stable_s[i])
        );
    end

    // Arbitration FSM state register, pulse register and held flag.
    // held follows the current state, so it trails each state change by one cycle.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_r <= S_IDLE;
            pulse_r <= '0;
            held_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            pulse_r <= pulse_next_s;
            held_r  <= (state_r != S_IDLE);
        end
    end

    // Next-state and next-pulse logic.
    // A pulse is only ever produced when leaving S_IDLE.
    always_comb begin
        state_next_s = state_r;
        pulse_next_s = '0;
        case (state_r)
            S_IDLE: begin
                if (|stable_s) begin
                    if (Enable) begin
                        pulse_next_s = pick_priority(stable_s);
                        state_next_s = S_HELD;
                    end else begin
                        state_next_s = S_LOCK;
                    end
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_HELD, S_LOCK: begin
                if (|stable_s) begin
                    state_next_s = state_r;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            default: begin
                // Illegal encoding: recover to idle without emitting a move.
                state_next_s = S_IDLE;
            end
        endcase
    end

    assign place      = pulse_r[BTN_C];
    assign up         = pulse_r[BTN_U];
    assign down       = pulse_r[BTN_D];
    assign left       = pulse_r[BTN_L];
    assign right      = pulse_r[BTN_R];
    assign held       = held_r;
    assign any_stable = |stable_s;

endmodule

// File: tb/tb_ttt_move_input.sv
module tb_ttt_move_input;

    localparam int D  = 4;
    localparam int CW = 3;
    localparam int HL = D + 2;

    localparam logic [4:0] B_C = 5'b00001;
    localparam logic [4:0] B_U = 5'b00010;
    localparam logic [4:0] B_D = 5'b00100;
    localparam logic [4:0] B_L = 5'b01000;
    localparam logic [4:0] B_R = 5'b10000;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    logic Enable = 1'b0;
    logic [4:0] btn_v = 5'b00000;
    logic left, right, up, down, place, held, any_stable;
    wire [4:0] obs_pulse = {right, left, down, up, place};

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model.
    // For each button, keep a window of the raw samples taken at recent edges.
    // A debounced level flips once the D synchronized samples (raw values from
    // two or more edges ago) all oppose it.
    bit         hist [5][HL];
    logic [4:0] m_stable = 5'b00000;
    bit         m_busy   = 1'b0;
    logic [4:0] m_pulse  = 5'b00000;
    bit         m_held   = 1'b0;

    always #5 Clk = ~Clk;

    ttt_move_input #(.DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
        .Clk(Clk), .Reset(Reset),
        .BtnL(btn_v[3]), .BtnR(btn_v[4]), .BtnU(btn_v[1]), .BtnD(btn_v[2]), .BtnC(btn_v[0]),
        .Enable(Enable),
        .left(left), .right(right), .up(up), .down(down), .place(place),
        .held(held), .any_stable(any_stable)
    );

    function automatic logic [4:0] pick(input logic [4:0] v);
        if (v[0])      return B_C;
        else if (v[1]) return B_U;
        else if (v[2]) return B_D;
        else if (v[3]) return B_L;
        else if (v[4]) return B_R;
        else           return 5'b00000;
    endfunction

    // Apply inputs for the next posedge, advance the model past that edge,
    // and return at the following negedge.
    task automatic drive_cycle(input logic [4:0] b, input logic en, input logic rst);
        logic [4:0] prev_stable;
        bit prev_busy;
        bit flip;
        btn_v  = b;
        Enable = en;
        Reset  = rst;
        if (!rst) begin
            for (int k = 0; k < 5; k++)
                for (int i = 0; i < HL; i++) hist[k][i] = 1'b0;
            m_stable = 5'b00000;
            m_busy   = 1'b0;
            m_pulse  = 5'b00000;
            m_held   = 1'b0;
        end else begin
            prev_stable = m_stable;
            prev_busy   = m_busy;
            for (int k = 0; k < 5; k++) begin
                for (int i = HL - 1; i > 0; i--) hist[k][i] = hist[k][i-1];
                hist[k][0] = b[k];
                flip = 1'b1;
                for (int i = 2; i < HL; i++)
                    if (hist[k][i] == m_stable[k]) flip = 1'b0;
                if (flip) m_stable[k] = ~m_stable[k];
            end
            m_held  = prev_busy;
            m_pulse = 5'b00000;
            if (!prev_busy) begin
                if (prev_stable != 5'b00000) begin
                    m_busy = 1'b1;
                    if (en) m_pulse = pick(prev_stable);
                end
            end else if (prev_stable == 5'b00000) begin
                m_busy = 1'b0;
            end
        end
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) drive_cycle(5'b00000, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) drive_cycle(5'b00000, 1'b0, 1'b1);
        n_checks++;
        if ({obs_pulse, held, any_stable} !== 7'b0000000) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b exp=0000000", {obs_pulse, held, any_stable});
        end
        n_checks++;
        if (dut.state_r !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_state got=%b exp=001", dut.state_r);
        end
    endtask

    task automatic test_right();
        int npulse = 0;
        int pulse_at = -1;
        int held_at = -1;
        for (int i = 0; i < 32; i++) begin
            drive_cycle((i < 20) ? B_R : 5'b00000, 1'b1, 1'b1);
            n_checks++;
            if (obs_pulse !== m_pulse || held !== m_held || any_stable !== |m_stable) begin
                n_fail++;
                $display("FAIL right_seq cyc=%0d got p=%b h=%b a=%b exp p=%b h=%b a=%b",
                         i, obs_pulse, held, any_stable, m_pulse, m_held, |m_stable);
            end
            if (obs_pulse != 5'b00000) begin
                npulse++;
                if (pulse_at < 0) pulse_at = i;
            end
            if (held && held_at < 0) held_at = i;
        end
        n_checks++;
        if (npulse != 1 || pulse_at != D + 2) begin
            n_fail++;
            $display("FAIL right_pulse got count=%0d at=%0d exp count=1 at=%0d", npulse, pulse_at, D + 2);
        end
        n_checks++;
        if (held_at != D + 3) begin
            n_fail++;
            $display("FAIL right_held_rise got=%0d exp=%0d", held_at, D + 3);
        end
    endtask

    task automatic test_bounce_up();
        int nup = 0;
        int up_at = -1;
        logic [4:0] b;
        for (int i = 0; i < 30; i++) begin
            if (i < 4) b = (i % 2 == 0) ? B_U : 5'b00000;
            else if (i < 20) b = B_U;
            else b = 5'b00000;
            drive_cycle(b, 1'b1, 1'b1);
            n_checks++;
            if (obs_pulse !== m_pulse || held !== m_held) begin
                n_fail++;
                $display("FAIL bounce_seq cyc=%0d got p=%b h=%b exp p=%b h=%b",
                         i, obs_pulse, held, m_pulse, m_held);
            end
            if (up) begin
                nup++;
                if (up_at < 0) up_at = i;
            end
        end
        n_checks++;
        if (nup != 1 || up_at != 4 + D + 2) begin
            n_fail++;
            $display("FAIL bounce_up got count=%0d at=%0d exp count=1 at=%0d", nup, up_at, 4 + D + 2);
        end
    endtask

    task automatic test_simul();
        logic [4:0] ph_btn [5] = '{B_L | B_C, B_L | B_C | B_D, 5'b00000, B_D, 5'b00000};
        int         ph_len [5] = '{12, 12, 8, 12, 8};
        int cnt [5][5];
        for (int p = 0; p < 5; p++) for (int k = 0; k < 5; k++) cnt[p][k] = 0;
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < ph_len[p]; i++) begin
                drive_cycle(ph_btn[p], 1'b1, 1'b1);
                n_checks++;
                if (obs_pulse !== m_pulse || held !== m_held) begin
                    n_fail++;
                    $display("FAIL simul_seq ph=%0d cyc=%0d got p=%b h=%b exp p=%b h=%b",
                             p, i, obs_pulse, held, m_pulse, m_held);
                end
                for (int k = 0; k < 5; k++) if (obs_pulse[k]) cnt[p][k]++;
            end
        end
        n_checks++;
        if (cnt[0][0] != 1 || cnt[0][3] != 0) begin
            n_fail++;
            $display("FAIL simul_place got place=%0d left=%0d exp place=1 left=0", cnt[0][0], cnt[0][3]);
        end
        n_checks++;
        if (cnt[1][2] != 0) begin
            n_fail++;
            $display("FAIL simul_down_ignored got=%0d exp=0", cnt[1][2]);
        end
        n_checks++;
        if (cnt[3][2] != 1) begin
            n_fail++;
            $display("FAIL simul_down_repress got=%0d exp=1", cnt[3][2]);
        end
    endtask

    task automatic test_lock();
        int npulse_locked = 0;
        int ndown = 0;
        for (int i = 0; i < 16; i++) begin
            drive_cycle(B_D, (i >= 8) ? 1'b1 : 1'b0, 1'b1);
            n_checks++;
            if (obs_pulse !== m_pulse || held !== m_held) begin
                n_fail++;
                $display("FAIL lock_seq cyc=%0d got p=%b h=%b exp p=%b h=%b",
                         i, obs_pulse, held, m_pulse, m_held);
            end
            if (obs_pulse != 5'b00000) npulse_locked++;
        end
        n_checks++;
        if (npulse_locked != 0 || held !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_hold got pulses=%0d held=%b exp pulses=0 held=1", npulse_locked, held);
        end
        for (int i = 0; i < 28; i++) begin
            drive_cycle((i >= 8 && i < 20) ? B_D : 5'b00000, 1'b1, 1'b1);
            n_checks++;
            if (obs_pulse !== m_pulse || held !== m_held) begin
                n_fail++;
                $display("FAIL lock_release_seq cyc=%0d got p=%b h=%b exp p=%b h=%b",
                         i, obs_pulse, held, m_pulse, m_held);
            end
            if (down) ndown++;
        end
        n_checks++;
        if (ndown != 1) begin
            n_fail++;
            $display("FAIL lock_repress got=%0d exp=1", ndown);
        end
    endtask

    task automatic test_reset_mid();
        int nup = 0;
        int up_at = -1;
        for (int i = 0; i < 12; i++) drive_cycle(B_U, 1'b1, 1'b1);
        drive_cycle(B_U, 1'b1, 1'b0);
        n_checks++;
        if ({obs_pulse, held, any_stable} !== 7'b0000000) begin
            n_fail++;
            $display("FAIL reset_mid_clear got=%b exp=0000000", {obs_pulse, held, any_stable});
        end
        // j counts edges after the reset edge; the first edge with Reset high is j=1,
        // so the re-debounced press pulses D+2 cycles later, at j = D+3.
        for (int j = 1; j <= 16; j++) begin
            drive_cycle(B_U, 1'b1, 1'b1);
            n_checks++;
            if (obs_pulse !== m_pulse || held !== m_held) begin
                n_fail++;
                $display("FAIL reset_mid_seq cyc=%0d got p=%b h=%b exp p=%b h=%b",
                         j, obs_pulse, held, m_pulse, m_held);
            end
            if (up) begin
                nup++;
                if (up_at < 0) up_at = j;
            end
        end
        n_checks++;
        if (nup != 1 || up_at != D + 3) begin
            n_fail++;
            $display("FAIL reset_mid_up got count=%0d at=%0d exp count=1 at=%0d", nup, up_at, D + 3);
        end
        for (int i = 0; i < 10; i++) drive_cycle(5'b00000, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        logic [4:0] b = 5'b00000;
        logic en = 1'b1;
        logic rst;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) b[$urandom_range(0, 4)] ^= 1'b1;
            if ($urandom_range(0, 29) == 0) en = ~en;
            rst = ($urandom_range(0, 299) != 0);
            drive_cycle(b, en, rst);
            n_checks++;
            if (obs_pulse !== m_pulse || held !== m_held || any_stable !== |m_stable) begin
                n_fail++;
                $display("FAIL random_seq cyc=%0d got p=%b h=%b a=%b exp p=%b h=%b a=%b",
                         i, obs_pulse, held, any_stable, m_pulse, m_held, |m_stable);
            end
            n_checks++;
            if (!$onehot0(obs_pulse)) begin
                n_fail++;
                $display("FAIL random_onehot cyc=%0d got=%b exp=at most one bit", i, obs_pulse);
            end
        end
    endtask

    initial begin
        @(negedge Clk);
        test_reset();
        test_right();
        test_bounce_up();
        test_simul();
        test_lock();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
